// File: rtl/simd_booth_pkg.sv
// Shared definitions for the SIMD sequential Booth multiplier.
//   MODE_*  : transaction mode encodings (lane split of the DATA_W operands)
//   state_e : controller states
//   lane_w  : lane width in bits for a given mode
package simd_booth_pkg;

  localparam logic [1:0] MODE_1X   = 2'b00;
  localparam logic [1:0] MODE_2X   = 2'b01;
  localparam logic [1:0] MODE_4X   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int lane_w(input logic [1:0] mode, input int data_w);
    case (mode)
      MODE_2X: return data_w / 2;
      MODE_4X: return data_w / 4;
      default: return data_w;
    endcase
  endfunction

endpackage

// File: rtl/booth_lane_step.sv
// One Booth step on a single LW-bit chunk of the accumulator/multiplier pair.
//   a_i/q_i/m_i : accumulator, multiplier and multiplicand chunk
//   add_i/sub_i : Booth decision of the lane this chunk belongs to
//   cin_i       : carry into the chunk (lane start: sub_i, else lower chunk)
//   a_fill_i    : bit shifted into the accumulator MSB
//   q_fill_i    : bit shifted into the multiplier MSB
//   sum_o       : A +/- M before the shift
//   cout_o      : carry out of the chunk (only used when chaining chunks)
//   sign_o      : true sign of A +/- M, valid even when the LW-bit sum overflows
//   a_o/q_o     : shifted accumulator and multiplier chunk
module booth_lane_step #(
  parameter int LW = 4
) (
  input  logic [LW-1:0] a_i,
  input  logic [LW-1:0] q_i,
  input  logic [LW-1:0] m_i,
  input  logic          add_i,
  input  logic          sub_i,
  input  logic          cin_i,
  input  logic          a_fill_i,
  input  logic          q_fill_i,
  output logic [LW-1:0] sum_o,
  output logic          cout_o,
  output logic          sign_o,
  output logic [LW-1:0] a_o,
  output logic [LW-1:0] q_o
);

  logic [LW-1:0] b;
  logic [LW:0]   full;

  // Subtraction is A + ~M + 1; the +1 arrives through cin_i at the lane start.
  assign b      = sub_i ? ~m_i : (add_i ? m_i : '0);
  assign full   = {1'b0, a_i} + {1'b0, b} + {{LW{1'b0}}, cin_i};
  assign sum_o  = full[LW-1:0];
  assign cout_o = full[LW];

  // Sign of the one-bit-wider result. A - (most-negative M) overflows the
  // LW-bit sum, but the shifted value fits again, so only the fill bit needs it.
  assign sign_o = a_i[LW-1] ^ b[LW-1] ^ full[LW];

  assign a_o = {a_fill_i, sum_o[LW-1:1]};
  assign q_o = {q_fill_i, q_i[LW-1:1]};

endmodule

// File: rtl/simd_booth_mult_seq.sv
// Sequential SIMD radix-2 Booth multiplier: one DATA_W multiply, or two or
// four independent signed multiplies on packed lanes, one Booth step per clock.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (mode, multiplicand, multiplier)
//   out_valid/out_ready  : result handshake (product, out_err)
//   product              : packed lane products, lane k at [k*2*LW +: 2*LW]
//   out_err              : reserved mode was issued (product is zero)
//   busy                 : transaction in RUN or DONE
// The datapath is four DATA_W/4 chunks; wider lanes chain the chunks through
// mode-controlled carry and shift-in muxes at the chunk boundaries.
module simd_booth_mult_seq
  import simd_booth_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   multiplicand,
  input  logic [DATA_W-1:0]   multiplier,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] product,
  output logic                out_err,
  output logic                busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SW     = DATA_W / 4;
  localparam int HW     = DATA_W / 2;
  localparam int CNT_W  = $clog2(DATA_W);

  if ((DATA_W % 4) != 0 || DATA_W < 8) begin : g_bad_param
    $error("DATA_W must be a multiple of 4 and at least 8");
  end

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [3:0]          qm1_q, qm1_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   a_nxt, q_nxt;
  logic [3:0]          lane_q0;   // Q LSB of each chunk, also next q_m1
  logic [3:0]          sum_lsb;   // LSB of each chunk's A +/- M
  logic [PROD_W-1:0]   prod_1x, prod_2x, prod_4x, prod_sel;
  logic                last_step;
  logic                unused_cout;

  // ---------------------------------------------------------------------
  // Per-chunk step logic
  // ---------------------------------------------------------------------
  for (genvar j = 0; j < 4; j++) begin : g_ch
    logic [1:0]    lo;        // lowest chunk of the lane this chunk is in
    logic          is_low, is_high;
    logic          add, sub, cin, afill, qfill;
    logic [SW-1:0] sum, a_o, q_o;
    logic          cout, sign;

    always_comb begin
      lo      = 2'(j);
      is_low  = 1'b1;
      is_high = 1'b1;
      case (mode_q)
        MODE_1X: begin
          lo      = 2'd0;
          is_low  = (j == 0);
          is_high = (j == 3);
        end
        MODE_2X: begin
          lo      = (j >= 2) ? 2'd2 : 2'd0;
          is_low  = ((j % 2) == 0);
          is_high = ((j % 2) == 1);
        end
        default: ;
      endcase
    end

    assign lane_q0[j] = q_q[j*SW];
    // Booth pair {Q[0], q_m1} always comes from the lane's lowest chunk.
    assign add = (lane_q0[lo] == 1'b0) && (qm1_q[lo] == 1'b1);
    assign sub = (lane_q0[lo] == 1'b1) && (qm1_q[lo] == 1'b0);

    if (j == 0) begin : g_cin_first
      assign cin = is_low ? sub : 1'b0;
    end else begin : g_cin_chain
      assign cin = is_low ? sub : g_ch[j-1].cout;
    end

    // At a lane top the sign replicates and the lane's A LSB enters Q MSB;
    // inside a lane the bits come from the chunk above.
    if (j == 3) begin : g_fill_top
      assign afill = sign;
      assign qfill = sum_lsb[lo];
    end else begin : g_fill_chain
      assign afill = is_high ? sign : g_ch[j+1].sum[0];
      assign qfill = is_high ? sum_lsb[lo] : q_q[(j+1)*SW];
    end

    booth_lane_step #(.LW(SW)) u_step (
      .a_i      (a_q[j*SW +: SW]),
      .q_i      (q_q[j*SW +: SW]),
      .m_i      (m_q[j*SW +: SW]),
      .add_i    (add),
      .sub_i    (sub),
      .cin_i    (cin),
      .a_fill_i (afill),
      .q_fill_i (qfill),
      .sum_o    (sum),
      .cout_o   (cout),
      .sign_o   (sign),
      .a_o      (a_o),
      .q_o      (q_o)
    );

    assign sum_lsb[j]          = sum[0];
    assign a_nxt[j*SW +: SW]   = a_o;
    assign q_nxt[j*SW +: SW]   = q_o;
  end

  // Carry out of the top chunk is the discarded lane-edge carry.
  assign unused_cout = g_ch[3].cout;

  // ---------------------------------------------------------------------
  // Product packing: lane k = {A_lane, Q_lane}
  // ---------------------------------------------------------------------
  assign prod_1x = {a_nxt, q_nxt};
  for (genvar k = 0; k < 2; k++) begin : g_pk2
    assign prod_2x[k*DATA_W +: DATA_W] = {a_nxt[k*HW +: HW], q_nxt[k*HW +: HW]};
  end
  for (genvar k = 0; k < 4; k++) begin : g_pk4
    assign prod_4x[k*HW +: HW] = {a_nxt[k*SW +: SW], q_nxt[k*SW +: SW]};
  end

  always_comb begin
    case (mode_q)
      MODE_2X: prod_sel = prod_2x;
      MODE_4X: prod_sel = prod_4x;
      default: prod_sel = prod_1x;
    endcase
  end

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  assign last_step = (state_q == RUN) &&
                     (cnt_q == CNT_W'(lane_w(mode_q, DATA_W) - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (mode == MODE_RSVD) ? DONE : RUN;
      RUN:  if (last_step) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        mode_d    = mode;
        m_d       = multiplicand;
        a_d       = '0;
        q_d       = multiplier;
        qm1_d     = '0;
        cnt_d     = '0;
        product_d = '0;
        err_d     = (mode == MODE_RSVD);
      end
      RUN: begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        qm1_d = lane_q0;
        cnt_d = cnt_q + 1'b1;
        if (last_step) product_d = prod_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_1X;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;
  assign out_err   = err_q;

endmodule
